// File: rtl/wci_ocp_timeout_guard.sv
// ---------------------------------------------------------------------------
// wci_ocp_timeout_guard : single-outstanding WCI/OCP request guard that turns a
// silent target into ERR responses. Optional macro: WCI_GUARD_COUNT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wci_ocp_timeout_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hC0DE_DEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  wciS0_MCmd,
  input  logic        wciS0_MAddrSpace,
  input  logic [3:0]  wciS0_MByteEn,
  input  logic [19:0] wciS0_MAddr,
  input  logic [31:0] wciS0_MData,
  input  logic [1:0]  wciS0_MFlag,
  output logic [1:0]  wciS0_SResp,
  output logic [31:0] wciS0_SData,
  output logic        wciS0_SThreadBusy,
  output logic [1:0]  wciS0_SFlag,
  output logic [2:0]  wciM0_MCmd,
  output logic        wciM0_MAddrSpace,
  output logic [3:0]  wciM0_MByteEn,
  output logic [19:0] wciM0_MAddr,
  output logic [31:0] wciM0_MData,
  output logic [1:0]  wciM0_MFlag,
  input  logic [1:0]  wciM0_SResp,
  input  logic [31:0] wciM0_SData,
  input  logic        wciM0_SThreadBusy,
  input  logic [1:0]  wciM0_SFlag,
  output logic        timeout_sticky,
  output logic        target_dead,
  output logic [15:0] timeout_count
);

  localparam logic [15:0] C_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ERRRSP = 3'd2,
    S_DRAIN  = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic        dead_q, dead_d;
  logic        dead_rsp_q, dead_rsp_d;

  // Address/data/flags are passed through unconditionally; only MCmd qualifies them.
  assign wciM0_MAddrSpace = wciS0_MAddrSpace;
  assign wciM0_MByteEn    = wciS0_MByteEn;
  assign wciM0_MAddr      = wciS0_MAddr;
  assign wciM0_MData      = wciS0_MData;
  assign wciM0_MFlag      = wciS0_MFlag;
  assign wciS0_SFlag      = wciM0_SFlag;
  assign timeout_sticky   = sticky_q;
  assign target_dead      = dead_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'h0000;
      sticky_q   <= 1'b0;
      dead_q     <= 1'b0;
      dead_rsp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      dead_q     <= dead_d;
      dead_rsp_q <= dead_rsp_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    sticky_d          = sticky_q;
    dead_d            = dead_q;
    dead_rsp_d        = 1'b0;
    wciM0_MCmd        = 3'd0;
    wciS0_SThreadBusy = 1'b1;
    wciS0_SResp       = 2'd0;
    wciS0_SData       = 32'h0000_0000;
    unique case (state_q)
      S_IDLE: begin
        wciM0_MCmd        = wciS0_MCmd;
        wciS0_SThreadBusy = wciM0_SThreadBusy;
        if (wciS0_MCmd != 3'd0 && !wciM0_SThreadBusy) begin
          state_d = S_WAIT;
          cnt_d   = 16'h0000;
        end
      end
      S_WAIT: begin
        wciS0_SResp = wciM0_SResp;
        wciS0_SData = wciM0_SData;
        // A response in the final wait cycle still beats the timeout.
        if (wciM0_SResp != 2'd0) begin
          state_d = S_IDLE;
        end else if (cnt_q == C_LAST) begin
          state_d = S_ERRRSP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ERRRSP: begin
        wciS0_SResp = 2'd3;
        wciS0_SData = ERR_DATA;
        sticky_d    = 1'b1;
        cnt_d       = 16'h0000;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        if (wciM0_SResp != 2'd0) begin
          state_d = S_IDLE;
        end else if (cnt_q == C_LAST) begin
          state_d = S_DEAD;
          dead_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DEAD: begin
        wciS0_SThreadBusy = 1'b0;
        dead_rsp_d        = (wciS0_MCmd != 3'd0);
        if (dead_rsp_q) begin
          wciS0_SResp = 2'd3;
          wciS0_SData = ERR_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef WCI_GUARD_COUNT_EN
  logic [15:0] tcount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcount_q <= 16'h0000;
    end else if (state_q == S_ERRRSP && tcount_q != 16'hFFFF) begin
      tcount_q <= tcount_q + 16'd1;
    end
  end

  assign timeout_count = tcount_q;
`else
  assign timeout_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wci_ocp_timeout_guard.sv
// ---------------------------------------------------------------------------
// tb_wci_ocp_timeout_guard : directed self-checking bench, TIMEOUT_CYCLES = 8.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wci_ocp_timeout_guard;

`ifdef WCI_GUARD_COUNT_EN
  localparam int c_cnt_en = 1;
`else
  localparam int c_cnt_en = 0;
`endif
  localparam logic [31:0] c_err = 32'hC0DE_DEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s_mcmd;
  logic        s_maddrspace;
  logic [3:0]  s_mbyteen;
  logic [19:0] s_maddr;
  logic [31:0] s_mdata;
  logic [1:0]  s_mflag;
  logic [1:0]  s_sresp;
  logic [31:0] s_sdata;
  logic        s_stb;
  logic [1:0]  s_sflag;
  logic [2:0]  m_mcmd;
  logic        m_maddrspace;
  logic [3:0]  m_mbyteen;
  logic [19:0] m_maddr;
  logic [31:0] m_mdata;
  logic [1:0]  m_mflag;
  logic [1:0]  m_sresp;
  logic [31:0] m_sdata;
  logic        m_stb;
  logic [1:0]  m_sflag;
  logic        sticky;
  logic        dead;
  logic [15:0] tcount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wci_ocp_timeout_guard #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hC0DE_DEAD)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .wciS0_MCmd       (s_mcmd),
    .wciS0_MAddrSpace (s_maddrspace),
    .wciS0_MByteEn    (s_mbyteen),
    .wciS0_MAddr      (s_maddr),
    .wciS0_MData      (s_mdata),
    .wciS0_MFlag      (s_mflag),
    .wciS0_SResp      (s_sresp),
    .wciS0_SData      (s_sdata),
    .wciS0_SThreadBusy(s_stb),
    .wciS0_SFlag      (s_sflag),
    .wciM0_MCmd       (m_mcmd),
    .wciM0_MAddrSpace (m_maddrspace),
    .wciM0_MByteEn    (m_mbyteen),
    .wciM0_MAddr      (m_maddr),
    .wciM0_MData      (m_mdata),
    .wciM0_MFlag      (m_mflag),
    .wciM0_SResp      (m_sresp),
    .wciM0_SData      (m_sdata),
    .wciM0_SThreadBusy(m_stb),
    .wciM0_SFlag      (m_sflag),
    .timeout_sticky   (sticky),
    .target_dead      (dead),
    .timeout_count    (tcount)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1..3 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Present a request in IDLE, check it is forwarded, and clock it in.
  task automatic accept(input logic [2:0] cmd, input logic [19:0] addr, input string tag);
    s_mcmd  = cmd;
    s_maddr = addr;
    settle();
    check({tag, "_fwd_cmd"}, 32'(m_mcmd), 32'(cmd));
    check({tag, "_fwd_addr"}, 32'(m_maddr), 32'(addr));
    tick();
    s_mcmd = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    s_mcmd = 3'd0; s_maddrspace = 1'b0; s_mbyteen = 4'hF; s_maddr = 20'h0;
    s_mdata = 32'h0; s_mflag = 2'd0;
    m_sresp = 2'd0; m_sdata = 32'h0; m_stb = 1'b0; m_sflag = 2'd0;
    tick(); tick();
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_dead", 32'(dead), 32'd0);
    check("rst_count", 32'(tcount), 32'd0);
    check("rst_sresp", 32'(s_sresp), 32'd0);
    rst = 1'b0;
    tick();

    // Flag passthrough and thread-busy mirroring in IDLE
    s_mflag = 2'd2; m_sflag = 2'd1; m_stb = 1'b1; s_mcmd = 3'd1;
    settle();
    check("mflag_pass", 32'(m_mflag), 32'd2);
    check("sflag_pass", 32'(s_sflag), 32'd1);
    check("idle_stb_mirror", 32'(s_stb), 32'd1);
    tick();
    s_mcmd = 3'd0; m_stb = 1'b0; s_mflag = 2'd0; m_sflag = 2'd0;
    settle();
    check("busy_no_accept", 32'(s_stb), 32'd0);
    tick();

    // WR answered with DVA in the third wait cycle
    s_mdata = 32'h5A5A_0001;
    accept(3'd1, 20'h00010, "wr1");
    settle();
    check("wr1_wait_cmd0", 32'(m_mcmd), 32'd0);
    check("wr1_wait_busy", 32'(s_stb), 32'd1);
    tick(); tick();
    m_sresp = 2'd1; m_sdata = 32'h0000_1234;
    settle();
    check("wr1_resp", 32'(s_sresp), 32'd1);
    check("wr1_sdata", s_sdata, 32'h0000_1234);
    tick();
    m_sresp = 2'd0; m_sdata = 32'h0;
    settle();
    check("wr1_idle_busy", 32'(s_stb), 32'd0);
    check("wr1_sticky", 32'(sticky), 32'd0);
    tick();

    // RD answered exactly in the last wait cycle: response wins
    accept(3'd2, 20'h00020, "rd_edge");
    for (int i = 0; i < 7; i++) tick();
    m_sresp = 2'd1; m_sdata = 32'hAAAA_5555;
    settle();
    check("edge_resp", 32'(s_sresp), 32'd1);
    check("edge_sdata", s_sdata, 32'hAAAA_5555);
    tick();
    m_sresp = 2'd0; m_sdata = 32'h0;
    settle();
    check("edge_idle_resp", 32'(s_sresp), 32'd0);
    check("edge_sticky", 32'(sticky), 32'd0);
    check("edge_count", 32'(tcount), 32'd0);
    check("edge_idle_busy", 32'(s_stb), 32'd0);
    tick();

    // RD with silent target: ERR after eight quiet wait cycles
    accept(3'd2, 20'h00030, "rd_to");
    for (int i = 0; i < 8; i++) begin
      settle();
      check("to_wait_quiet", 32'(s_sresp), 32'd0);
      tick();
    end
    settle();
    check("to_err_resp", 32'(s_sresp), 32'd3);
    check("to_err_data", s_sdata, c_err);
    check("to_err_busy", 32'(s_stb), 32'd1);
    tick();
    settle();
    check("to_err_one_cycle", 32'(s_sresp), 32'd0);
    check("to_sticky", 32'(sticky), 32'd1);
    check("to_count", 32'(tcount), 32'(1 * c_cnt_en));
    tick();
    // Late DVA during drain is swallowed
    m_sresp = 2'd1; m_sdata = 32'h1111_2222;
    settle();
    check("late_not_fwd", 32'(s_sresp), 32'd0);
    check("late_sdata_zero", s_sdata, 32'h0);
    check("late_busy", 32'(s_stb), 32'd1);
    tick();
    m_sresp = 2'd0; m_sdata = 32'h0;
    settle();
    check("late_busy_drop", 32'(s_stb), 32'd0);
    accept(3'd1, 20'h00040, "wr2");
    m_sresp = 2'd1;
    settle();
    check("wr2_resp", 32'(s_sresp), 32'd1);
    tick();
    m_sresp = 2'd0;
    tick();

    // Silent through wait and drain: target declared dead
    accept(3'd2, 20'h00050, "rd_dead");
    for (int i = 0; i < 8; i++) tick();
    settle();
    check("dead_err_resp", 32'(s_sresp), 32'd3);
    tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      check("drain_busy", 32'(s_stb), 32'd1);
      check("drain_not_dead", 32'(dead), 32'd0);
      tick();
    end
    m_stb = 1'b1;
    settle();
    check("dead_flag", 32'(dead), 32'd1);
    check("dead_count", 32'(tcount), 32'(2 * c_cnt_en));
    for (int r = 0; r < 3; r++) begin
      s_mcmd = 3'd2;
      settle();
      check("dead_stb_zero", 32'(s_stb), 32'd0);
      check("dead_cmd_block", 32'(m_mcmd), 32'd0);
      check("dead_no_early_resp", 32'(s_sresp), 32'd0);
      tick();
      s_mcmd = 3'd0;
      settle();
      check("dead_rsp", 32'(s_sresp), 32'd3);
      check("dead_rsp_data", s_sdata, c_err);
      tick();
    end
    settle();
    check("dead_one_rsp_each", 32'(s_sresp), 32'd0);
    m_stb = 1'b0;
    rst = 1'b1;
    settle();
    check("dead_rst_clear", 32'(dead), 32'd0);
    check("dead_rst_sticky", 32'(sticky), 32'd0);
    check("dead_rst_count", 32'(tcount), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset pulse mid-WAIT abandons the request
    accept(3'd1, 20'h00060, "wr3");
    rst = 1'b1;
    settle();
    check("midrst_resp", 32'(s_sresp), 32'd0);
    rst = 1'b0;
    settle();
    check("midrst_sticky", 32'(sticky), 32'd0);
    check("midrst_dead", 32'(dead), 32'd0);
    check("midrst_count", 32'(tcount), 32'd0);
    tick();
    settle();
    check("midrst_no_resp", 32'(s_sresp), 32'd0);
    check("midrst_idle_busy", 32'(s_stb), 32'd0);
    accept(3'd1, 20'h00070, "wr4");
    m_sresp = 2'd1;
    settle();
    check("wr4_resp", 32'(s_sresp), 32'd1);
    tick();
    m_sresp = 2'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
